// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller for the E stage: owns HI/LO, models
// multi-cycle latency with a busy counter, and reports Start/Busy to the hazard unit.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic        MDUEn,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] MDUOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [63:0]      pend_r;
    logic             commit_ok_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;

    logic             start_op_s;
    logic             div_op_s;
    logic             start_s;
    logic             div_by_zero_s;
    logic             done_s;
    logic             mthi_s;
    logic             mtlo_s;
    logic [CNT_W-1:0] cnt_load_s;
    logic [63:0]      result_s;

    function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = {{32{a[31]}}, a};
        bx = {{32{b[31]}}, b};
        return ax * bx;
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = {32'd0, a};
        bx = {32'd0, b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}; zero divisor yields zero (never committed).
    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] res;
        if (b == 32'd0) begin
            res = 64'd0;
        end else begin
            res = {a % b, a / b};
        end
        return res;
    endfunction

    // Magnitude divide then re-sign, so 0x80000000 / -1 wraps cleanly to 0x80000000.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        ma = a[31] ? (32'd0 - a) : a;
        mb = b[31] ? (32'd0 - b) : b;
        if (mb == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (a[31] ^ b[31]) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (a[31]) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    assign start_op_s    = (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);
    assign div_op_s      = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
    assign start_s       = MDUEn && !busy_r && start_op_s;
    assign div_by_zero_s = div_op_s && (SrcB == 32'd0);
    assign cnt_load_s    = div_op_s ? DIV_LOAD : MULT_LOAD;
    assign done_s        = (state_r == ST_RUN) && (cnt_r <= CNT_ONE);
    assign mthi_s        = MDUEn && !busy_r && (MDUOp == OP_MTHI);
    assign mtlo_s        = MDUEn && !busy_r && (MDUOp == OP_MTLO);

    // 64-bit result of the op presented this cycle, captured only on start
    always_comb begin
        result_s = 64'd0;
        case (MDUOp)
            OP_MULT:  result_s = mul_signed(SrcA, SrcB);
            OP_MULTU: result_s = mul_unsigned(SrcA, SrcB);
            OP_DIV:   result_s = div_signed(SrcA, SrcB);
            OP_DIVU:  result_s = div_unsigned(SrcA, SrcB);
            default:  result_s = 64'd0;
        endcase
    end

    // FSM state register with registered busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_RUN);
        end
    end

    // FSM next-state logic; a zero count in RUN is treated as done
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Latency counter and pending result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= CNT_ZERO;
            pend_r      <= 64'd0;
            commit_ok_r <= 1'b0;
        end else if (start_s) begin
            cnt_r       <= cnt_load_s;
            pend_r      <= result_s;
            commit_ok_r <= !div_by_zero_s;
        end else if (state_r == ST_RUN) begin
            if (cnt_r > CNT_ONE) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= CNT_ZERO;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Committed HI/LO: completion commit, or mthi/mtlo while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (done_s) begin
            if (commit_ok_r) begin
                hi_r <= pend_r[63:32];
                lo_r <= pend_r[31:0];
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end else if (mthi_s) begin
            hi_r <= SrcA;
        end else if (mtlo_s) begin
            lo_r <= SrcA;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // FSM outputs: start strobe and HI/LO read port
    always_comb begin
        Start  = start_s;
        MDUOut = 32'd0;
        case (MDUOp)
            OP_MFHI: MDUOut = hi_r;
            OP_MFLO: MDUOut = lo_r;
            default: MDUOut = 32'd0;
        endcase
    end

    assign Busy = busy_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the driver queues hand-computed expectations per
// cycle, and a negedge monitor pops and compares them against the DUT outputs.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUOp;
    logic        MDUEn;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Start;
    logic        Busy;
    logic [31:0] MDUOut;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .MDUOp  (MDUOp),
        .MDUEn  (MDUEn),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Start  (Start),
        .Busy   (Busy),
        .MDUOut (MDUOut)
    );

    typedef struct packed {
        logic        es;
        logic        eb;
        logic [31:0] eo;
        logic [2:0]  m;
    } exp_t;

    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] CALL = 3'b111;

    exp_t  exp_q[$];
    string nm_q[$];
    int    tests = 0;
    int    fails = 0;

    task automatic step(input logic rs, input logic [3:0] op, input logic en,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic es, input logic eb, input logic [31:0] eo,
                        input logic [2:0] m, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rs;
        MDUOp = op;
        MDUEn = en;
        SrcA  = a;
        SrcB  = b;
        e.es = es;
        e.eb = eb;
        e.eo = eo;
        e.m  = m;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic busy_wait(input int n, input logic [3:0] op, input logic [31:0] eo, input string nm);
        for (int i = 0; i < n; i++) begin
            step(1'b0, op, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, eo, CALL, nm);
        end
    endtask

    // Monitor: compare whatever the driver queued for this cycle
    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            if (e.m[0]) begin
                tests++;
                if (Start !== e.es) begin
                    fails++;
                    $display("FAIL %s Start got %0b expected %0b", n, Start, e.es);
                end
            end
            if (e.m[1]) begin
                tests++;
                if (Busy !== e.eb) begin
                    fails++;
                    $display("FAIL %s Busy got %0b expected %0b", n, Busy, e.eb);
                end
            end
            if (e.m[2]) begin
                tests++;
                if (MDUOut !== e.eo) begin
                    fails++;
                    $display("FAIL %s MDUOut got %08h expected %08h", n, MDUOut, e.eo);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        MDUOp = 4'd0;
        MDUEn = 1'b0;
        SrcA  = 32'd0;
        SrcB  = 32'd0;

        step(1'b1, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, NONE, "rst");
        step(1'b0, 4'd5, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, CALL, "rst_hi");
        step(1'b0, 4'd6, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, CALL, "rst_lo");

        // mult -2 * 3
        step(1'b0, 4'd1, 1'b1, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0, 32'd0, CALL, "mult_start");
        busy_wait(5, 4'd5, 32'd0, "mult_busy");
        step(1'b0, 4'd5, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, CALL, "mult_hi");
        step(1'b0, 4'd6, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFA, CALL, "mult_lo");

        // multu max * max
        step(1'b0, 4'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd0, CALL, "multu_start");
        busy_wait(5, 4'd6, 32'hFFFFFFFA, "multu_busy");
        step(1'b0, 4'd5, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFE, CALL, "multu_hi");
        step(1'b0, 4'd6, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h00000001, CALL, "multu_lo");

        // div -7 / 2
        step(1'b0, 4'd3, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32'd0, CALL, "div_start");
        busy_wait(10, 4'd0, 32'd0, "div_busy");
        step(1'b0, 4'd5, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, CALL, "div_hi");
        step(1'b0, 4'd6, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFD, CALL, "div_lo");

        // div overflow corner
        step(1'b0, 4'd3, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd0, CALL, "divovf_start");
        busy_wait(10, 4'd0, 32'd0, "divovf_busy");
        step(1'b0, 4'd5, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h00000000, CALL, "divovf_hi");
        step(1'b0, 4'd6, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h80000000, CALL, "divovf_lo");

        // mthi/mtlo then divu by zero; an mthi during busy must be dropped
        step(1'b0, 4'd7, 1'b1, 32'h11, 32'd0, 1'b0, 1'b0, 32'd0, CALL, "mthi");
        step(1'b0, 4'd8, 1'b1, 32'h22, 32'd0, 1'b0, 1'b0, 32'd0, CALL, "mtlo");
        step(1'b0, 4'd5, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h11, CALL, "mthi_rd");
        step(1'b0, 4'd4, 1'b1, 32'd7, 32'd0, 1'b1, 1'b0, 32'd0, CALL, "divz_start");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                step(1'b0, 4'd7, 1'b1, 32'hAB, 32'd0, 1'b0, 1'b1, 32'd0, CALL, "divz_mthi_busy");
            end else begin
                step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, CALL, "divz_busy");
            end
        end
        step(1'b0, 4'd5, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h11, CALL, "divz_hi");
        step(1'b0, 4'd6, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h22, CALL, "divz_lo");

        // mult 0x10000^2 with divs issued while busy (ignored)
        step(1'b0, 4'd1, 1'b1, 32'h10000, 32'h10000, 1'b1, 1'b0, 32'd0, CALL, "ign_start");
        step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, CALL, "ign_c1");
        step(1'b0, 4'd3, 1'b1, 32'd100, 32'd7, 1'b0, 1'b1, 32'd0, CALL, "ign_div_c2");
        step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, CALL, "ign_c3");
        step(1'b0, 4'd7, 1'b1, 32'hAB, 32'd0, 1'b0, 1'b1, 32'd0, CALL, "ign_mthi_c4");
        step(1'b0, 4'd3, 1'b1, 32'd100, 32'd7, 1'b0, 1'b1, 32'd0, CALL, "ign_div_c5");
        step(1'b0, 4'd5, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h00000001, CALL, "ign_hi");
        step(1'b0, 4'd6, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h00000000, CALL, "ign_lo");

        // reset in busy cycle 4 of a div aborts it with no late commit
        step(1'b0, 4'd3, 1'b1, 32'd100, 32'd7, 1'b1, 1'b0, 32'd0, CALL, "rstmid_start");
        busy_wait(3, 4'd0, 32'd0, "rstmid_busy");
        step(1'b1, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, CALL, "rstmid_assert");
        step(1'b0, 4'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, CALL, "rstmid_hi");
        step(1'b0, 4'd6, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, CALL, "rstmid_lo");
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, CALL, "rstmid_nocommit");
        end

        // back-to-back: mult, then mtlo in first idle cycle, then disabled ops
        step(1'b0, 4'd1, 1'b1, 32'd5, 32'd6, 1'b1, 1'b0, 32'd0, CALL, "b2b_start");
        busy_wait(5, 4'd6, 32'd0, "b2b_busy");
        step(1'b0, 4'd8, 1'b1, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, CALL, "b2b_mtlo");
        step(1'b0, 4'd6, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h5, CALL, "b2b_mflo");
        step(1'b0, 4'd5, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0, CALL, "b2b_mfhi");
        step(1'b0, 4'd1, 1'b0, 32'd3, 32'd3, 1'b0, 1'b0, 32'd0, CALL, "en0_mult");
        step(1'b0, 4'd7, 1'b0, 32'h77, 32'd0, 1'b0, 1'b0, 32'd0, CALL, "en0_mthi");
        step(1'b0, 4'd5, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0, CALL, "en0_hi");
        step(1'b0, 4'd9, 1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0, CALL, "op9");
        step(1'b0, 4'd6, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h5, CALL, "op9_after");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencing controller for the E-stage multiply/divide resource of the pipelined MIPS core, sitting alongside the ALU.
- Accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo from E, owns the HI/LO registers, and models the multi-cycle latency with a busy counter.
- Exports start/busy so the hazard unit can stall MD-class instructions in D.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- MDUOp  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
- MDUEn  input  1  E-stage instruction valid (low on bubble/flush).
- SrcA  input  32  rs operand (forwarded).
- SrcB  input  32  rt operand (forwarded).
- Start  output  1  combinational: MDUEn & ~Busy & MDUOp in {1..4}.
- Busy  output  1  registered: multi-cycle operation in flight.
- MDUOut  output  32  combinational: HI when MDUOp==5, LO when MDUOp==6, else 0.

Behaviour:
- Reset (synchronous, highest priority): HI=0, LO=0, Busy=0, counter=0, pending result discarded. Reset mid-operation aborts it and leaves HI/LO at 0.
- States: IDLE (Busy=0) and RUN (Busy=1, counter>0).
- IDLE, Start=1 at edge t0:
  - latch the 64-bit result into a pending register.
  - counter <= MULT_CYCLES or DIV_CYCLES; Busy <= 1.
  - HI/LO are not modified at t0.
- RUN:
  - Each edge, if counter>1 then counter decrements.
  - If counter==1: HI/LO <= pending, Busy <= 0, counter <= 0.
  - Busy is therefore high for exactly N cycles after the start cycle. New HI/LO are visible on MDUOut in cycle N+1 after start, which is when Busy is first 0.
- Results:
  - mult: {HI,LO} = signed SrcA * signed SrcB (64-bit).
  - multu: same, unsigned.
  - div: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (SrcB==0, div or divu): operation still runs DIV_CYCLES with Busy high, but HI/LO keep their prior values at completion.
- mthi/mtlo:
  - Write SrcA to HI/LO at the edge, only when MDUEn & ~Busy.
  - Same instruction is never also a start.
- mfhi/mflo: MDUOut is a pure combinational read of the committed HI/LO. It is valid only when Busy=0; the hazard unit guarantees this.
- Any MD op (1-8) with MDUEn=1 while Busy=1 is ignored: no state change, no restart, MDUOut still driven from committed HI/LO. The hazard unit is responsible for preventing this; the controller must stay self-consistent.
- MDUEn=0: no state change regardless of MDUOp; counter/Busy continue normally.
- The counter width must hold max(MULT_CYCLES, DIV_CYCLES) without wrap.

Test Plan:
- Reset, then mult SrcA=0xFFFFFFFE, SrcB=3 -> Start=1 that cycle; Busy=1 for exactly 5 cycles; mfhi in cycle 6 reads 0xFFFFFFFF, mflo reads 0xFFFFFFFA.
- multu 0xFFFFFFFF * 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- div -7 / 2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with divu 7/0 preceded by mthi 0x11, mtlo 0x22 -> HI/LO remain 0x11/0x22 after 10 busy cycles.
- Issue mult at cycle 0, then div with MDUEn=1 at cycles 2 and 5 -> both ignored; Busy falls after cycle 5; HI/LO hold the mult result only; mthi 0xAB while busy also ignored.
- Mid-operation reset: div started, reset asserted in busy cycle 4 -> next cycle Busy=0, HI=LO=0; no late commit in later cycles.
- Back-to-back: mult completes, Busy=0 cycle, mtlo 0x5 then mflo next cycle -> MDUOut=0x5; MDUEn=0 with MDUOp=1 -> Start=0, Busy stays 0.
